// File: rtl/gpr_wb_queue.sv
// gpr_wb_queue: writeback FIFO draining jal/datapath register writes onto the regfile port, with a bypass lookup.
module gpr_wb_queue #(
  parameter int DEPTH = 4,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AW-1:0]          in_rd,
  input  logic [DW-1:0]          in_data,
  input  logic                   jal_valid,
  output logic                   jal_ready,
  input  logic [DW-1:0]          jal_addr,
  input  logic                   wr_stall,
  output logic [AW-1:0]          rw,
  output logic [DW-1:0]          busW,
  output logic                   regWrite,
  input  logic [AW-1:0]          q_ra,
  output logic                   q_hit,
  output logic [DW-1:0]          q_data,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [AW-1:0] rd_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rw_q, enq_rd;
  logic [DW-1:0] busw_q, enq_data;
  logic          regwrite_q, full, push, deq;
  assign full      = count_q == CW'(DEPTH);
  assign jal_ready = !full;
  assign in_ready  = !full && !jal_valid;
  assign enq_rd    = jal_valid ? AW'(31) : in_rd;
  assign enq_data  = jal_valid ? jal_addr : in_data;
  // writes to r0 still complete the handshake but never occupy a slot
  assign push      = ((jal_valid && jal_ready) || (in_valid && in_ready)) && enq_rd != '0;
  assign deq       = count_q != '0 && !wr_stall;
  assign count_d   = count_q + CW'(push) - CW'(deq);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rw_q       <= '0;
      busw_q     <= '0;
      regwrite_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (deq) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        rw_q     <= rd_q[rd_ptr_q];
        busw_q   <= data_q[rd_ptr_q];
      end
      regwrite_q <= deq;
      count_q    <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      rd_q[wr_ptr_q]   <= enq_rd;
      data_q[wr_ptr_q] <= enq_data;
    end
  end
  // oldest-to-youngest scan so the newest matching entry wins; output register is lowest priority
  always_comb begin
    q_hit  = regwrite_q && rw_q == q_ra;
    q_data = q_hit ? busw_q : '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (CW'(k) < count_q && rd_q[rd_ptr_q + PW'(k)] == q_ra) begin
        q_hit  = 1'b1;
        q_data = data_q[rd_ptr_q + PW'(k)];
      end
    end
    if (q_ra == '0) begin
      q_hit  = 1'b0;
      q_data = '0;
    end
  end
  assign rw       = rw_q;
  assign busW     = busw_q;
  assign regWrite = regwrite_q;
  assign count    = count_q;
endmodule

// File: tb/tb_gpr_wb_queue.sv
// tb_gpr_wb_queue: directed stimulus with a scoreboard of expected regfile commits.
module tb_gpr_wb_queue;
  localparam int DEPTH = 4;
  logic        clk = 1'b0, rst = 1'b0;
  logic        in_valid = 1'b0, jal_valid = 1'b0, wr_stall = 1'b0;
  logic [4:0]  in_rd = '0, q_ra = '0;
  logic [31:0] in_data = '0, jal_addr = '0;
  logic        in_ready, jal_ready, regWrite, q_hit;
  logic [4:0]  rw;
  logic [31:0] busW, q_data;
  logic [2:0]  count;
  int checks = 0, errors = 0;
  logic [36:0] sb [$];
  logic [36:0] exp_out;
  logic        last_ja, last_ia;

  gpr_wb_queue #(.DEPTH(DEPTH), .DW(32), .AW(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd),
    .in_data(in_data), .jal_valid(jal_valid), .jal_ready(jal_ready), .jal_addr(jal_addr),
    .wr_stall(wr_stall), .rw(rw), .busW(busW), .regWrite(regWrite), .q_ra(q_ra),
    .q_hit(q_hit), .q_data(q_data), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // one clock: check readiness against the model, advance the model, then check the commit port
  task automatic tick();
    logic full, deq;
    #1;
    full = sb.size() == DEPTH;
    chk("jal_ready", 64'(jal_ready), 64'(!full));
    chk("in_ready", 64'(in_ready), 64'(!full && !jal_valid));
    last_ja = jal_valid && !full;
    last_ia = in_valid && !full && !jal_valid;
    deq = sb.size() != 0 && !wr_stall;
    if (deq) exp_out = sb.pop_front();
    if (last_ja) sb.push_back({5'd31, jal_addr});
    else if (last_ia && in_rd != 0) sb.push_back({in_rd, in_data});
    @(posedge clk);
    #1;
    chk("regWrite", 64'(regWrite), 64'(deq));
    if (deq) begin
      chk("rw", 64'(rw), 64'(exp_out[36:32]));
      chk("busW", 64'(busW), 64'(exp_out[31:0]));
    end
    chk("count", 64'(count), 64'(sb.size()));
  endtask

  task automatic send(input logic [4:0] rd, input logic [31:0] d);
    in_valid = 1'b1; in_rd = rd; in_data = d;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_regWrite", 64'(regWrite), 64'd0);
    chk("rst_rw", 64'(rw), 64'd0);
    chk("rst_busW", 64'(busW), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    rst = 1'b1;
    // reset mid-operation
    send(5'd3, 32'h11); send(5'd4, 32'h22); send(5'd6, 32'h33);
    #2 rst = 1'b0;
    #1;
    chk("midrst_regWrite", 64'(regWrite), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) tick();
    // single write
    send(5'd5, 32'h1234);
    repeat (2) tick();
    // fill and stall
    wr_stall = 1'b1;
    for (int i = 1; i <= 4; i++) send(5'(i), 32'h100 + 32'(i));
    in_valid = 1'b1; jal_valid = 1'b0;
    #1;
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_jal_ready", 64'(jal_ready), 64'd0);
    in_valid = 1'b0;
    wr_stall = 1'b0;
    repeat (5) tick();
    // jal priority over datapath
    jal_valid = 1'b1; jal_addr = 32'h400008;
    in_valid = 1'b1; in_rd = 5'd7; in_data = 32'h77;
    tick();
    chk("prio_jal_acc", 64'(last_ja), 64'd1);
    jal_valid = 1'b0;
    tick();
    chk("prio_in_acc", 64'(last_ia), 64'd1);
    in_valid = 1'b0;
    repeat (3) tick();
    // zero register drop
    send(5'd0, 32'hFFFF);
    q_ra = 5'd0;
    #1;
    chk("zero_q_hit", 64'(q_hit), 64'd0);
    chk("zero_q_data", 64'(q_data), 64'd0);
    repeat (2) tick();
    // bypass ordering
    wr_stall = 1'b1;
    send(5'd9, 32'hA); send(5'd9, 32'hB);
    q_ra = 5'd9;
    #1;
    chk("byp_hit", 64'(q_hit), 64'd1);
    chk("byp_data", 64'(q_data), 64'hB);
    wr_stall = 1'b0;
    tick();
    chk("byp_drain_hit", 64'(q_hit), 64'd1);
    chk("byp_drain_data", 64'(q_data), 64'hB);
    tick();
    chk("byp_out_data", 64'(q_data), 64'hB);
    tick();
    chk("byp_empty_hit", 64'(q_hit), 64'd0);
    q_ra = 5'd0;
    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
